// File: rtl/mul_signed.sv
// mul_signed: signed WI x WI radix-4 Booth multiplier with full 2*WI-bit product.
//    iClk   : clock, registered path updates on rising edge
//    iRsn   : asynchronous active-low reset (clears registered path only)
//    w, x   : signed operands (weight, activation)
//    y      : combinational product w*x
//    iValid : qualifies w/x for the registered path
//    oValid : registered-path valid
//    oY     : registered product, holds while no new valid product arrives
// Optional macro MUL_PIPE2_EN: registers the two halves of the adder tree,
// making the registered path 2 cycles deep; y stays combinational.
module mul_signed #(
   parameter int WI = 8
) (
   input  logic                   iClk,
   input  logic                   iRsn,
   input  logic signed [WI-1:0]   w,
   input  logic signed [WI-1:0]   x,
   output logic signed [2*WI-1:0] y,
   input  logic                   iValid,
   output logic                   oValid,
   output logic signed [2*WI-1:0] oY
);
   localparam int W2 = 2 * WI;
   localparam int NX = (WI + 1) / 2;
   // leaf count rounded up to a power of two so the heap-ordered tree is balanced
   localparam int NP = 1 << $clog2(NX);
   logic signed [2*NX-1:0] xs;
   logic        [2*NX:0]   xe;
   logic signed [W2-1:0]   we;
   logic signed [W2-1:0]   mag;
   logic                   neg;
   logic signed [W2-1:0]   node [2*NP-1];
   logic                   valid_d, valid_q;
   logic signed [W2-1:0]   y_d, y_q;
   always_comb begin
      // odd WI gains one sign bit; the appended 0 is the implicit x[-1] of Booth recoding
      xs = (2*NX)'(x);
      xe = {xs, 1'b0};
      we = W2'(w);
      mag = '0;
      neg = 1'b0;
      for (int k = 0; k < NP; k++) node[NP-1+k] = '0;
      for (int i = 0; i < NX; i++) begin
         mag = (xe[2*i+1] ^ xe[2*i]) ? we : ((xe[2*i+2] ^ xe[2*i+1]) ? we <<< 1 : '0);
         neg = xe[2*i+2] & ~(xe[2*i+1] & xe[2*i]);
         node[NP-1+i] = (neg ? -mag : mag) <<< (2*i);
      end
      // node[k] sums children 2k+1 and 2k+2; wraparound is exact since the product fits W2 bits
      for (int k = NP - 2; k >= 0; k--) node[k] = node[2*k+1] + node[2*k+2];
   end
   assign y = node[0];
`ifdef MUL_PIPE2_EN
   logic                 v1_d, v1_q;
   logic signed [W2-1:0] lo_n, hi_n, lo_d, lo_q, hi_d, hi_q;
   if (NP > 1) begin : g_split
      assign lo_n = node[1];
      assign hi_n = node[2];
   end else begin : g_single
      assign lo_n = node[0];
      assign hi_n = '0;
   end
   always_comb begin
      v1_d    = iValid;
      lo_d    = iValid ? lo_n : lo_q;
      hi_d    = iValid ? hi_n : hi_q;
      valid_d = v1_q;
      y_d     = v1_q ? lo_q + hi_q : y_q;
   end
   always_ff @(posedge iClk or negedge iRsn) begin
      if (!iRsn) begin
         v1_q <= 1'b0;
         lo_q <= '0;
         hi_q <= '0;
      end else begin
         v1_q <= v1_d;
         lo_q <= lo_d;
         hi_q <= hi_d;
      end
   end
`else
   always_comb begin
      valid_d = iValid;
      y_d     = iValid ? y : y_q;
   end
`endif
   always_ff @(posedge iClk or negedge iRsn) begin
      if (!iRsn) begin
         valid_q <= 1'b0;
         y_q     <= '0;
      end else begin
         valid_q <= valid_d;
         y_q     <= y_d;
      end
   end
   assign oValid = valid_q;
   assign oY     = y_q;
endmodule

// File: tb/tb_mul_signed.sv
// tb_mul_signed: scoreboard bench for mul_signed (WI=8 main instance, WI=5 combinational instance).
module tb_mul_signed;
   localparam int WI = 8;
`ifdef MUL_PIPE2_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   typedef struct {int v; int c;} exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic iv = 1'b0;
   logic signed [WI-1:0] w = '0, x = '0;
   logic signed [2*WI-1:0] y, oy;
   logic ov;
   logic signed [4:0] w5 = '0, x5 = '0;
   logic signed [9:0] y5, oy5;
   logic ov5;
   int total = 0, bad = 0, cyc = 0, last = 0;
   exp_t q[$];
   exp_t e;
   mul_signed #(.WI(WI)) dut (.iClk(clk), .iRsn(rst_n), .w(w), .x(x), .y(y),
      .iValid(iv), .oValid(ov), .oY(oy));
   mul_signed #(.WI(5)) dut5 (.iClk(clk), .iRsn(rst_n), .w(w5), .x(x5), .y(y5),
      .iValid(1'b0), .oValid(ov5), .oY(oy5));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string n, input int a, input int ex);
      total++;
      if (a !== ex) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d t=%0t", n, a, ex, $time);
      end
   endtask
   // call right after a rising edge: operands are sampled on the next edge
   task automatic step(input bit v, input int a, input int b);
      @(posedge clk);
      #1;
      w = a[WI-1:0];
      x = b[WI-1:0];
      iv = v;
      if (v) q.push_back('{a * b, cyc + LAT});
   endtask
   always @(negedge clk) begin
      if (rst_n) begin
         chk("comb_y", y, int'(w) * int'(x));
         while (q.size() > 0 && q[0].c < cyc) begin
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_out got=none want=%0d at_cyc=%0d", e.v, e.c);
         end
         if (ov) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_valid got=oY %0d want=no valid cyc=%0d", oy, cyc);
            end else begin
               e = q.pop_front();
               chk("oY", oy, e.v);
               chk("latency", cyc, e.c);
               last = e.v;
            end
         end else chk("oY_hold", oy, last);
      end
   end
   initial begin
      int ta[5] = '{-128, 127, -1, 0, 127};
      int tb[5] = '{-128, -128, -1, -77, 127};
      int te[5] = '{16384, -16256, 1, 0, 16129};
      w = -7;
      x = 6;
      #3;
      chk("rst_y", y, -42);
      chk("rst_oY", oy, 0);
      chk("rst_oValid", ov, 0);
      for (int i = 0; i < 5; i++) begin
         w = ta[i][WI-1:0];
         x = tb[i][WI-1:0];
         #1;
         chk("corner_y", y, te[i]);
      end
      for (int a = -128; a < 128; a++)
         for (int b = -128; b < 128; b++) begin
            w = a[WI-1:0];
            x = b[WI-1:0];
            #1;
            chk("exh8_y", y, a * b);
         end
      for (int a = -16; a < 16; a++)
         for (int b = -16; b < 16; b++) begin
            w5 = a[4:0];
            x5 = b[4:0];
            #1;
            chk("exh5_y", y5, a * b);
         end
      chk("rst_hold_oY", oy, 0);
      w = 0;
      x = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(0, 0, 0);
      step(1, 3, 4);
      step(1, -5, 6);
      step(1, 7, -8);
      repeat (4) step(0, 1, 1);
      step(1, 2, 9);
      step(0, 2, 9);
      step(1, -3, 3);
      repeat (4) step(0, 0, 0);
      repeat (300) step($urandom_range(0, 1), $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
      step(1, 5, 5);
      step(1, 6, 6);
      step(1, 7, 7);
      @(negedge clk);
      #2;
      chk("pre_rst_oValid", ov, 1);
      rst_n = 1'b0;
      iv = 1'b0;
      #1;
      chk("async_rst_oValid", ov, 0);
      chk("async_rst_oY", oy, 0);
      q.delete();
      last = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) step(0, 4, 4);
      step(1, -9, 11);
      repeat (4) step(0, 0, 0);
      chk("drain", q.size(), 0);
      chk("wi5_oValid", ov5, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
